// File: rtl/sdram_arb_pkg.sv
// Shared types for the two-master SDRAM Avalon-MM arbiter.
package sdram_arb_pkg;
  typedef enum logic [1:0] {IDLE, GNT0, GNT1} arb_state_e;
  typedef logic mst_id_t;
  localparam int ARB_NUM_MST = 2;
endpackage

// File: rtl/sdram_arb_tag_fifo.sv
// Tag FIFO that records which master issued each outstanding read, in issue order.
module sdram_arb_tag_fifo
  import sdram_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk_riscv,
  input  logic    rst_in,
  input  logic    push,
  input  mst_id_t din,
  input  logic    pop,
  output logic    full,
  output logic    empty,
  output mst_id_t head
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DEPTH-1:0] mem;
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push, do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A push into a full FIFO is only safe when a pop frees the head slot this cycle.
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk_riscv or negedge rst_in) begin
    if (!rst_in) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

// File: rtl/sdram_avmm_arbiter.sv
// Two-master Avalon-MM arbiter in front of the SDR SDRAM controller slave.
// SDRAM_ARB_FIXED_PRIO_EN: port 0 wins every tie (no round-robin state).
module sdram_avmm_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W    = 22,
  parameter int DATA_W    = 16,
  parameter int MAX_OUTST = 4
) (
  input  logic                clk_riscv,
  input  logic                rst_in,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,
  output logic [ADDR_W-1:0]   s_address,
  output logic                s_read,
  output logic                s_write,
  output logic [DATA_W-1:0]   s_writedata,
  output logic [DATA_W/8-1:0] s_byteenable,
  input  logic                s_waitrequest,
  input  logic [DATA_W-1:0]   s_readdata,
  input  logic                s_readdatavalid,
  output logic                err_rdv
);
  arb_state_e             state, state_nxt;
  logic [ARB_NUM_MST-1:0] rd, wr, cand;
  mst_id_t                gnt_id, sel;
  logic                   drv, push, pop;
  logic                   fifo_full, fifo_empty;
  mst_id_t                fifo_head;

  assign rd   = {m1_read, m0_read};
  assign wr   = {m1_write, m0_write};
  // Reads need a free tag slot; writes never do.
  assign cand = wr | (rd & {ARB_NUM_MST{~fifo_full}});

`ifdef SDRAM_ARB_FIXED_PRIO_EN
  assign gnt_id = cand[0] ? 1'b0 : 1'b1;
`else
  mst_id_t last;
  assign gnt_id = (&cand) ? ~last : (cand[0] ? 1'b0 : 1'b1);

  always_ff @(posedge clk_riscv or negedge rst_in) begin
    if (!rst_in)                    last <= 1'b1;
    else if (state == IDLE && |cand) last <= gnt_id;
  end
`endif

  always_ff @(posedge clk_riscv or negedge rst_in) begin
    if (!rst_in) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    drv            = 1'b0;
    sel            = 1'b0;
    push           = 1'b0;
    s_address      = '0;
    s_read         = 1'b0;
    s_write        = 1'b0;
    s_writedata    = '0;
    s_byteenable   = '0;
    m0_waitrequest = 1'b1;
    m1_waitrequest = 1'b1;
    case (state)
      IDLE:    if (|cand) state_nxt = gnt_id ? GNT1 : GNT0;
      GNT0:    drv = 1'b1;
      GNT1:    begin drv = 1'b1; sel = 1'b1; end
      default: state_nxt = IDLE;
    endcase
    if (drv) begin
      s_address    = sel ? m1_address    : m0_address;
      s_read       = sel ? m1_read       : m0_read;
      s_write      = sel ? m1_write      : m0_write;
      s_writedata  = sel ? m1_writedata  : m0_writedata;
      s_byteenable = sel ? m1_byteenable : m0_byteenable;
      if (sel) m1_waitrequest = s_waitrequest;
      else     m0_waitrequest = s_waitrequest;
      push = s_read & ~s_waitrequest;
      // Leave on accept, or if the master abandons its request mid-grant.
      if (((s_read | s_write) & ~s_waitrequest) | ~(s_read | s_write))
        state_nxt = IDLE;
    end
  end

  sdram_arb_tag_fifo #(.DEPTH(MAX_OUTST)) u_tag_fifo (
    .clk_riscv (clk_riscv),
    .rst_in    (rst_in),
    .push      (push),
    .din       (sel),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  assign pop              = s_readdatavalid & ~fifo_empty;
  assign m0_readdatavalid = pop & ~fifo_head;
  assign m1_readdatavalid = pop &  fifo_head;
  assign m0_readdata      = rst_in ? s_readdata : '0;
  assign m1_readdata      = rst_in ? s_readdata : '0;

  always_ff @(posedge clk_riscv or negedge rst_in) begin
    if (!rst_in)                              err_rdv <= 1'b0;
    else if (s_readdatavalid && fifo_empty)   err_rdv <= 1'b1;
  end
endmodule

// File: tb/tb_sdram_avmm_arbiter.sv
// Directed bench for sdram_avmm_arbiter: arbitration, tag routing, FIFO limits, errors, reset.
module tb_sdram_avmm_arbiter;
  localparam int AW = 22;
  localparam int DW = 16;
  localparam int BW = DW / 8;
`ifdef SDRAM_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic          clk_riscv = 1'b0;
  logic          rst_in = 1'b0;
  logic [AW-1:0] m0_address = '0, m1_address = '0;
  logic          m0_read = 1'b0, m0_write = 1'b0, m1_read = 1'b0, m1_write = 1'b0;
  logic [DW-1:0] m0_writedata = '0, m1_writedata = '0;
  logic [BW-1:0] m0_byteenable = '0, m1_byteenable = '0;
  logic          m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
  logic [DW-1:0] m0_readdata, m1_readdata;
  logic [AW-1:0] s_address;
  logic          s_read, s_write, err_rdv;
  logic [DW-1:0] s_writedata, s_readdata;
  logic [BW-1:0] s_byteenable;
  logic          s_waitrequest = 1'b0;
  logic          s_readdatavalid;

  logic          auto_rsp = 1'b0, man_rdv = 1'b0;
  logic [DW-1:0] man_data = '0;
  logic [2:0]    rd_pipe = '0;
  logic [DW-1:0] d_pipe [3] = '{default: '0};
  int            acc_q[$];
  int            rdv_port[$];
  int            rdv_data[$];
  int            n_tests = 0, n_fail = 0;

  always #5 clk_riscv = ~clk_riscv;

  assign s_readdatavalid = auto_rsp ? rd_pipe[2] : man_rdv;
  assign s_readdata      = auto_rsp ? d_pipe[2]  : man_data;

  sdram_avmm_arbiter dut (
    .clk_riscv(clk_riscv), .rst_in(rst_in),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .s_address(s_address), .s_read(s_read), .s_write(s_write),
    .s_writedata(s_writedata), .s_byteenable(s_byteenable),
    .s_waitrequest(s_waitrequest), .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid),
    .err_rdv(err_rdv)
  );

  // Slave model: logs accepted reads and returns the read address as data 3 cycles later.
  always begin : slave_mdl
    logic          acc;
    logic [DW-1:0] a;
    @(negedge clk_riscv);
    #3;
    acc = s_read && !s_waitrequest;
    a   = s_address[DW-1:0];
    if (acc) acc_q.push_back(m0_waitrequest ? 1 : 0);
    @(posedge clk_riscv);
    #1;
    d_pipe[2] = d_pipe[1];
    d_pipe[1] = d_pipe[0];
    d_pipe[0] = a;
    rd_pipe   = {rd_pipe[1:0], acc};
    #2;
    if (auto_rsp && m0_readdatavalid) begin rdv_port.push_back(0); rdv_data.push_back(int'(m0_readdata)); end
    if (auto_rsp && m1_readdatavalid) begin rdv_port.push_back(1); rdv_data.push_back(int'(m1_readdata)); end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Raise a read on port p, wait for its grant, optionally return data in the accept cycle.
  task automatic issue(input int p, input logic [AW-1:0] a, input bit with_pop);
    bit ok = 1'b0;
    if (p == 0) begin m0_read = 1'b1; m0_address = a; end
    else        begin m1_read = 1'b1; m1_address = a; end
    for (int i = 0; i < 8 && !ok; i++) begin
      @(negedge clk_riscv);
      if (((p == 0) ? m0_waitrequest : m1_waitrequest) == 1'b0) begin
        ok = 1'b1;
        if (with_pop) begin
          man_rdv = 1'b1;
          #1;
          chk("s4_pop_m0_rdv", m0_readdatavalid, 1);
          chk("s4_pop_m1_rdv", m1_readdatavalid, 0);
        end
      end
    end
    chk("issue_grant", ok, 1);
    @(negedge clk_riscv);
    m0_read = 1'b0; m1_read = 1'b0; man_rdv = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int base, rbase, exp_p;
    repeat (2) @(negedge clk_riscv);
    chk("rst_m0_wait", m0_waitrequest, 1);
    chk("rst_m1_wait", m1_waitrequest, 1);
    chk("rst_s_read", s_read, 0);
    chk("rst_s_write", s_write, 0);
    chk("rst_rdv", {m0_readdatavalid, m1_readdatavalid}, 0);
    chk("rst_err", err_rdv, 0);
    chk("rst_s_addr", s_address, 0);
    @(negedge clk_riscv);
    rst_in = 1'b1;

    // Both ports read continuously with an auto-responding slave.
    @(negedge clk_riscv);
    base = acc_q.size(); rbase = rdv_port.size();
    auto_rsp = 1'b1;
    m0_read = 1'b1; m0_address = 22'h100;
    m1_read = 1'b1; m1_address = 22'h200;
    repeat (16) @(negedge clk_riscv);
    m0_read = 1'b0; m1_read = 1'b0;
    repeat (8) @(negedge clk_riscv);
    auto_rsp = 1'b0;
    chk("s2_n_acc", acc_q.size() - base, 8);
    chk("s2_n_rdv", rdv_port.size() - rbase, 8);
    for (int i = 0; i < 8; i++) begin
      exp_p = FIXED ? 0 : (i % 2);
      chk("s2_acc_port", acc_q[base + i], exp_p);
      chk("s2_rdv_port", rdv_port[rbase + i], exp_p);
      chk("s2_rdv_data", rdv_data[rbase + i], (exp_p != 0) ? 32'h200 : 32'h100);
    end
    chk("s2_err", err_rdv, 0);

    // Single write from port 0.
    m0_write = 1'b1; m0_address = 22'h10; m0_writedata = 16'hA5A5; m0_byteenable = 2'b11;
    #1 chk("s1_pre_write", s_write, 0);
    @(negedge clk_riscv);
    chk("s1_write", s_write, 1);
    chk("s1_addr", s_address, 22'h10);
    chk("s1_wdata", s_writedata, 16'hA5A5);
    chk("s1_be", s_byteenable, 2'b11);
    chk("s1_m0_wait", m0_waitrequest, 0);
    chk("s1_m1_wait", m1_waitrequest, 1);
    @(negedge clk_riscv);
    chk("s1_post_write", s_write, 0);
    chk("s1_m1_wait2", m1_waitrequest, 1);
    m0_write = 1'b0;
    @(negedge clk_riscv);
    chk("s1_idle_write", s_write, 0);

    // Fill the tag FIFO from port 1; the write path must stay open.
    base = acc_q.size();
    m1_read = 1'b1; m1_address = 22'h300;
    repeat (12) @(negedge clk_riscv);
    chk("s3_n_acc4", acc_q.size() - base, 4);
    chk("s3_m1_stall", m1_waitrequest, 1);
    chk("s3_no_read", s_read, 0);
    m0_write = 1'b1; m0_address = 22'h20; m0_writedata = 16'h1234;
    @(negedge clk_riscv);
    chk("s3_wr_gnt", s_write, 1);
    chk("s3_wr_m0_wait", m0_waitrequest, 0);
    chk("s3_wr_m1_wait", m1_waitrequest, 1);
    @(negedge clk_riscv);
    m0_write = 1'b0;
    man_data = 16'hBEEF; man_rdv = 1'b1;
    #1;
    chk("s3_ret_m1_rdv", m1_readdatavalid, 1);
    chk("s3_ret_m0_rdv", m0_readdatavalid, 0);
    chk("s3_ret_data", m1_readdata, 16'hBEEF);
    @(negedge clk_riscv);
    man_rdv = 1'b0;
    @(negedge clk_riscv);
    chk("s3_5th_gnt", m1_waitrequest, 0);
    @(negedge clk_riscv);
    chk("s3_n_acc5", acc_q.size() - base, 5);
    m1_read = 1'b0;
    man_rdv = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 chk("s3_drain", m1_readdatavalid, 1);
      @(negedge clk_riscv);
    end
    man_rdv = 1'b0;

    // Push and pop in the same cycle with two reads outstanding.
    issue(0, 22'h400, 1'b0);
    issue(1, 22'h500, 1'b0);
    issue(0, 22'h600, 1'b1);
    man_rdv = 1'b1;
    #1;
    chk("s4_ret1_m1", m1_readdatavalid, 1);
    chk("s4_ret1_m0", m0_readdatavalid, 0);
    @(negedge clk_riscv);
    #1;
    chk("s4_ret2_m0", m0_readdatavalid, 1);
    chk("s4_ret2_m1", m1_readdatavalid, 0);
    @(negedge clk_riscv);
    man_rdv = 1'b0;
    chk("s4_err", err_rdv, 0);

    // Spurious readdatavalid with nothing outstanding.
    man_rdv = 1'b1;
    #1;
    chk("s5_m0_rdv", m0_readdatavalid, 0);
    chk("s5_m1_rdv", m1_readdatavalid, 0);
    @(negedge clk_riscv);
    man_rdv = 1'b0;
    chk("s5_err_set", err_rdv, 1);
    repeat (3) @(negedge clk_riscv);
    chk("s5_err_sticky", err_rdv, 1);

    // Reset while a stalled grant is active, then a tie.
    m0_write = 1'b1; m0_address = 22'h30; s_waitrequest = 1'b1;
    @(negedge clk_riscv);
    chk("s6_stall_write", s_write, 1);
    chk("s6_stall_wait", m0_waitrequest, 1);
    rst_in = 1'b0;
    #1;
    chk("s6_rst_write", s_write, 0);
    chk("s6_rst_read", s_read, 0);
    chk("s6_rst_m0_wait", m0_waitrequest, 1);
    chk("s6_rst_m1_wait", m1_waitrequest, 1);
    chk("s6_rst_err", err_rdv, 0);
    chk("s6_rst_addr", s_address, 0);
    m0_write = 1'b0; s_waitrequest = 1'b0;
    @(negedge clk_riscv);
    rst_in = 1'b1;
    m0_write = 1'b1; m0_address = 22'h40;
    m1_write = 1'b1; m1_address = 22'h50;
    @(negedge clk_riscv);
    chk("s6_tie_m0_wait", m0_waitrequest, 0);
    chk("s6_tie_m1_wait", m1_waitrequest, 1);
    chk("s6_tie_addr", s_address, 22'h40);
    @(negedge clk_riscv);
    m0_write = 1'b0; m1_write = 1'b0;
    repeat (2) @(negedge clk_riscv);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
